// File: rtl/audio_pkg.sv
// Shared audio constants and the serializer state type.
package audio_pkg;
    localparam int SAMPLE_W   = 16;
    localparam int FRAME_BITS = 32;
    localparam int SLOT_BITS  = 16;
    localparam int BIT_CNT_W  = $clog2(FRAME_BITS);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} ser_state_t;
endpackage

// File: rtl/sample_serializer_if.sv
// Parallel sample stream from the echo stage: 16-bit sample with one-cycle ready strobe.
interface sample_serializer_if;
    import audio_pkg::*;

    logic [SAMPLE_W-1:0] sample_in;
    logic                ready;

    modport master (output sample_in, output ready);
    modport slave  (input  sample_in, input  ready);
endinterface

// File: rtl/sample_serializer_bclk_gen.sv
// Bit-clock divider: toggles bclk every CLK_DIV cycles while run is high, held low otherwise.
module bclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic bclk,
    output logic fall_tick
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    assign tick      = run && (div_cnt == DIV_W'(CLK_DIV - 1));
    assign fall_tick = tick && bclk;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (!run) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (tick) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/sample_serializer.sv
// Mono sample to left-justified serial frame (same word in both slots), with one
// holding register between the sample strobe and the frame boundary.
module sample_serializer
    import audio_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                clk,
    input  logic                reset,
    sample_serializer_if.slave  smp,
    output logic                bclk,
    output logic                lrclk,
    output logic                sdata,
    output logic                frame_start,
    output logic                underrun
);
    ser_state_t            state;
    logic [SAMPLE_W-1:0]   hold;
    logic [SAMPLE_W-1:0]   frame_word;
    logic [SAMPLE_W-1:0]   shift;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic [BIT_CNT_W-1:0]  bit_cnt_nxt;
    logic                  pending;
    logic                  fall_tick;
    logic                  boundary;

    bclk_gen #(.CLK_DIV(CLK_DIV)) u_bclk_gen (
        .clk       (clk),
        .reset     (reset),
        .run       (state == RUN),
        .bclk      (bclk),
        .fall_tick (fall_tick)
    );

    assign bit_cnt_nxt = bit_cnt + 1'b1;
    assign boundary    = fall_tick && (bit_cnt == BIT_CNT_W'(FRAME_BITS - 1));
    assign lrclk       = (state == RUN) && bit_cnt[BIT_CNT_W-1];
    assign sdata       = (state == RUN) && shift[SAMPLE_W-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            hold        <= '0;
            frame_word  <= '0;
            shift       <= '0;
            bit_cnt     <= '0;
            pending     <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            case (state)
                IDLE: begin
                    if (smp.ready) begin
                        state       <= RUN;
                        frame_word  <= smp.sample_in;
                        shift       <= smp.sample_in;
                        bit_cnt     <= '0;
                        pending     <= 1'b0;
                        frame_start <= 1'b1;
                    end
                end
                RUN: begin
                    // A strobe landing on the boundary edge bypasses hold entirely.
                    if (smp.ready && !boundary) begin
                        hold    <= smp.sample_in;
                        pending <= 1'b1;
                    end
                    if (fall_tick) begin
                        bit_cnt <= bit_cnt_nxt;
                        if (boundary) begin
                            frame_start <= 1'b1;
                            pending     <= 1'b0;
                            if (smp.ready) begin
                                frame_word <= smp.sample_in;
                                shift      <= smp.sample_in;
                            end else if (pending) begin
                                frame_word <= hold;
                                shift      <= hold;
                            end else begin
                                shift    <= frame_word;
                                underrun <= 1'b1;
                            end
                        end else if (bit_cnt_nxt == BIT_CNT_W'(SLOT_BITS)) begin
                            shift <= frame_word;
                        end else begin
                            shift <= {shift[SAMPLE_W-2:0], 1'b0};
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sample_serializer.sv
// Bench for sample_serializer: time-indexed frame model checked every cycle plus directed frame captures.
module tb_sample_serializer;
    localparam int CLK_DIV   = 4;
    localparam int FRAME_CYC = 64 * CLK_DIV;
    localparam int BIT_CYC   = 2 * CLK_DIV;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic bclk, lrclk, sdata, frame_start, underrun;

    sample_serializer_if sif ();

    sample_serializer #(.CLK_DIV(CLK_DIV)) dut (
        .clk         (clk),
        .reset       (reset),
        .smp         (sif),
        .bclk        (bclk),
        .lrclk       (lrclk),
        .sdata       (sdata),
        .frame_start (frame_start),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int ur_count = 0;
    int last_fs = 0;
    bit started = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad < 40)
                $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Model: phase counter within the current frame, the word being sent, and the newest held sample.
    bit          m_run = 1'b0;
    int          m_c = 0;
    logic [15:0] m_word = '0;
    logic [15:0] m_hold = '0;
    bit          m_pend = 1'b0;
    bit          m_uf = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_run = 1'b0; m_c = 0; m_word = '0; m_hold = '0; m_pend = 1'b0; m_uf = 1'b0;
        end else if (!m_run) begin
            if (sif.ready) begin
                m_run = 1'b1; m_c = 0; m_word = sif.sample_in; m_pend = 1'b0; m_uf = 1'b0;
            end
        end else if (m_c == FRAME_CYC - 1) begin
            m_c = 0;
            m_uf = 1'b0;
            if (sif.ready) begin
                m_word = sif.sample_in; m_pend = 1'b0;
            end else if (m_pend) begin
                m_word = m_hold; m_pend = 1'b0;
            end else begin
                m_uf = 1'b1;
            end
        end else begin
            m_c++;
            if (sif.ready) begin
                m_hold = sif.sample_in; m_pend = 1'b1;
            end
        end
    end

    function automatic logic [4:0] model_out();
        int bitn;
        logic e_bclk, e_lr, e_sd, e_fs, e_ur;
        if (!m_run) return 5'b0;
        bitn   = m_c / BIT_CYC;
        e_bclk = ((m_c / CLK_DIV) % 2) == 1;
        e_lr   = bitn >= 16;
        e_sd   = m_word[15 - (bitn % 16)];
        e_fs   = (m_c == 0);
        e_ur   = (m_c == 0) && m_uf;
        return {e_bclk, e_lr, e_sd, e_fs, e_ur};
    endfunction

    always @(negedge clk) begin
        if (started) begin
            check("cycle_outputs", {27'b0, bclk, lrclk, sdata, frame_start, underrun}, {27'b0, model_out()});
            if (underrun) ur_count++;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sif.ready = 1'b0;
    endtask

    task automatic start(input logic [15:0] v);
        @(negedge clk);
        sif.ready = 1'b1;
        sif.sample_in = v;
        @(negedge clk);
        sif.ready = 1'b0;
        check("first_frame_start", {31'b0, frame_start}, 32'd1);
        check("first_msb", {31'b0, sdata}, {31'b0, v[15]});
        last_fs = cyc;
    endtask

    task automatic wait_boundary(input logic exp_ur, input bit chk_spacing);
        bit seen = 1'b0;
        for (int n = 0; n < 300 && !seen; n++) begin
            @(negedge clk);
            sif.ready = 1'b0;
            seen = frame_start;
        end
        check("boundary_reached", {31'b0, seen}, 32'd1);
        check("boundary_underrun", {31'b0, underrun}, {31'b0, exp_ur});
        if (chk_spacing) check("frame_spacing", cyc - last_fs, FRAME_CYC);
        last_fs = cyc;
    endtask

    // Called at the frame_start cycle; samples sdata/lrclk at each bclk rise of the frame.
    task automatic capture(input int at1, input logic [15:0] v1, input int at2, input logic [15:0] v2,
                           input logic [15:0] exp_word);
        logic [15:0] left = '0;
        logic [15:0] right = '0;
        int nbits = 0;
        int lr_err = 0;
        logic prev;
        prev = bclk;
        for (int i = 0; i < FRAME_CYC; i++) begin
            if (i > 0) @(negedge clk);
            sif.ready = 1'b0;
            if (i == at1) begin sif.ready = 1'b1; sif.sample_in = v1; end
            if (i == at2) begin sif.ready = 1'b1; sif.sample_in = v2; end
            if (bclk && !prev) begin
                if (nbits < 16) begin
                    left = {left[14:0], sdata};
                    if (lrclk !== 1'b0) lr_err++;
                end else begin
                    right = {right[14:0], sdata};
                    if (lrclk !== 1'b1) lr_err++;
                end
                nbits++;
            end
            prev = bclk;
        end
        check("left_slot", {16'b0, left}, {16'b0, exp_word});
        check("right_slot", {16'b0, right}, {16'b0, exp_word});
        check("lrclk_pattern", lr_err, 0);
        check("bits_per_frame", nbits, 32);
    endtask

    int ur0;

    initial begin
        sif.ready = 1'b0;
        sif.sample_in = '0;
        #3 reset = 1'b1;
        started = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_outputs", {27'b0, bclk, lrclk, sdata, frame_start, underrun}, 32'd0);

        // Single sample, then underrun repeats it
        start(16'hA5C3);
        capture(-1, '0, -1, '0, 16'hA5C3);
        wait_boundary(1'b1, 1'b1);

        // One strobe per frame keeps frames fed
        do_reset();
        ur0 = ur_count;
        start(16'h8001);
        capture(100, 16'h7FFE, -1, '0, 16'h8001);
        wait_boundary(1'b0, 1'b1);
        capture(100, 16'h8001, -1, '0, 16'h7FFE);
        wait_boundary(1'b0, 1'b1);
        capture(-1, '0, -1, '0, 16'h8001);
        check("no_underrun_fed", ur_count - ur0, 0);

        // Starved stream repeats the last sample
        do_reset();
        start(16'h1234);
        ur0 = ur_count;
        capture(-1, '0, -1, '0, 16'h1234);
        for (int k = 0; k < 2; k++) begin
            wait_boundary(1'b1, 1'b1);
            capture(-1, '0, -1, '0, 16'h1234);
        end
        check("underrun_pulses", ur_count - ur0, 2);

        // Newest of two strobes wins
        do_reset();
        start(16'h5555);
        capture(50, 16'h1111, 150, 16'h2222, 16'h5555);
        wait_boundary(1'b0, 1'b1);
        capture(-1, '0, -1, '0, 16'h2222);

        // Strobe on the boundary edge loads directly, nothing left pending
        do_reset();
        start(16'h3333);
        capture(FRAME_CYC - 1, 16'h0F0F, -1, '0, 16'h3333);
        wait_boundary(1'b0, 1'b1);
        capture(-1, '0, -1, '0, 16'h0F0F);
        wait_boundary(1'b1, 1'b1);

        // Asynchronous reset in the right slot
        do_reset();
        start(16'hC00C);
        repeat (200) @(negedge clk);
        check("in_right_slot", {31'b0, lrclk}, 32'd1);
        begin
            int c0;
            c0 = cyc;
            #2 reset = 1'b1;
            #1;
            check("async_reset_outputs", {27'b0, bclk, lrclk, sdata, frame_start, underrun}, 32'd0);
            check("no_edge_during_reset", cyc - c0, 0);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("post_reset_idle", {27'b0, bclk, lrclk, sdata, frame_start, underrun}, 32'd0);
        start(16'hABCD);
        capture(-1, '0, -1, '0, 16'hABCD);

        @(negedge clk);
        started = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
